// File: rtl/tcnt_counter.sv
// Timer count generator: prescaled up/down 8-bit counter with software load.
// Produces TCNT, count_enable and a one-cycle step tick for the overflow comparator.
module tcnt_counter #(
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  pclk,
   input  logic                  preset_n,
   input  logic [DATA_WIDTH-1:0] TDR,
   input  logic                  load,
   input  logic                  timer_en,
   input  logic                  count_up_down,
   input  logic [1:0]            cks,
   output logic [DATA_WIDTH-1:0] TCNT,
   output logic                  count_enable,
   output logic                  tick
);

   localparam int unsigned DIV_W = 4;

   typedef enum logic {
      IDLE  = 1'b0,
      COUNT = 1'b1
   } state_t;

   state_t                state;
   state_t                state_nxt;
   logic [DIV_W-1:0]      div_cnt;
   logic [DIV_W-1:0]      div_nxt;
   logic [DIV_W-1:0]      div_term;
   logic [1:0]            cks_q;
   logic [DATA_WIDTH-1:0] tcnt_nxt;
   logic                  tick_nxt;
   logic                  count_enable_nxt;

   // Terminal divider value N-1 with N = 2 << cks
   assign div_term = DIV_W'((32'd2 << cks) - 32'd1);

   // State register
   always_ff @(posedge pclk) begin
      if (!preset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (timer_en)  state_nxt = COUNT;
         COUNT:   if (!timer_en) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Output / datapath next values; load beats a step, a cks change or disable restarts the divider
   always_comb begin
      tcnt_nxt         = TCNT;
      div_nxt          = div_cnt;
      tick_nxt         = 1'b0;
      count_enable_nxt = (state_nxt == COUNT);
      if (load) begin
         tcnt_nxt = TDR;
         div_nxt  = '0;
      end else if (state_nxt == IDLE) begin
         div_nxt = '0;
      end else if (cks != cks_q) begin
         div_nxt = '0;
      end else if (div_cnt == div_term) begin
         div_nxt  = '0;
         tick_nxt = 1'b1;
         tcnt_nxt = count_up_down ? (TCNT - DATA_WIDTH'(1)) : (TCNT + DATA_WIDTH'(1));
      end else begin
         div_nxt = div_cnt + DIV_W'(1);
      end
   end

   // Registered outputs and divider
   always_ff @(posedge pclk) begin
      if (!preset_n) begin
         TCNT         <= '0;
         count_enable <= 1'b0;
         tick         <= 1'b0;
         div_cnt      <= '0;
         cks_q        <= cks;
      end else begin
         TCNT         <= tcnt_nxt;
         count_enable <= count_enable_nxt;
         tick         <= tick_nxt;
         div_cnt      <= div_nxt;
         cks_q        <= cks;
      end
   end

endmodule

// File: tb/tb_tcnt_counter.sv
// Self-checking bench for tcnt_counter: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural model.
module tb_tcnt_counter;

   logic       pclk = 1'b0;
   logic       preset_n;
   logic [7:0] TDR;
   logic       load;
   logic       timer_en;
   logic       count_up_down;
   logic [1:0] cks;
   logic [7:0] TCNT;
   logic       count_enable;
   logic       tick;

   int checks = 0;
   int errors = 0;

   // Model: edges counted since the current period began; a step fires when that reaches N
   int         m_tcnt  = 0;
   int         m_phase = 0;
   bit         m_ce    = 1'b0;
   bit         m_tick  = 1'b0;
   logic [1:0] m_cks_prev = 2'b00;

   always #5 pclk = ~pclk;

   tcnt_counter #(.DATA_WIDTH(8)) dut (
      .pclk          (pclk),
      .preset_n      (preset_n),
      .TDR           (TDR),
      .load          (load),
      .timer_en      (timer_en),
      .count_up_down (count_up_down),
      .cks           (cks),
      .TCNT          (TCNT),
      .count_enable  (count_enable),
      .tick          (tick)
   );

   task automatic clk1();
      int n;
      @(posedge pclk);
      n = 2 << cks;
      if (!preset_n) begin
         m_tcnt  = 0;
         m_ce    = 1'b0;
         m_tick  = 1'b0;
         m_phase = 0;
      end else begin
         m_ce   = timer_en;
         m_tick = 1'b0;
         if (load) begin
            m_tcnt  = int'(TDR);
            m_phase = 0;
         end else if (!timer_en || cks != m_cks_prev) begin
            m_phase = 0;
         end else begin
            m_phase++;
            if (m_phase == n) begin
               m_tcnt  = count_up_down ? (m_tcnt + 255) % 256 : (m_tcnt + 1) % 256;
               m_tick  = 1'b1;
               m_phase = 0;
            end
         end
      end
      m_cks_prev = cks;
      #1;
   endtask

   task automatic test_reset();
      preset_n = 1'b0; load = 1'b1; TDR = 8'hA5; timer_en = 1'b1;
      count_up_down = 1'b0; cks = 2'b10;
      clk1();
      clk1();
      checks++;
      if (TCNT !== 8'h00) begin errors++; $display("FAIL reset_tcnt got=%h exp=00", TCNT); end
      checks++;
      if (count_enable !== 1'b0) begin errors++; $display("FAIL reset_ce got=%b exp=0", count_enable); end
      checks++;
      if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick got=%b exp=0", tick); end
      preset_n = 1'b1; load = 1'b0; timer_en = 1'b0; cks = 2'b00;
      clk1();
      checks++;
      if (TCNT !== 8'h00 || count_enable !== 1'b0) begin
         errors++; $display("FAIL reset_idle tcnt=%h ce=%b exp 00/0", TCNT, count_enable);
      end
   endtask

   task automatic test_basic();
      timer_en = 1'b1; cks = 2'b00; count_up_down = 1'b0;
      checks++;
      if (TCNT !== 8'h00 || count_enable !== 1'b0) begin
         errors++; $display("FAIL basic_cyc0 tcnt=%h ce=%b exp 00/0", TCNT, count_enable);
      end
      for (int k = 1; k < 10; k++) begin
         clk1();
         checks++;
         if (TCNT !== 8'(k / 2)) begin
            errors++; $display("FAIL basic_tcnt cyc=%0d got=%h exp=%h", k, TCNT, 8'(k / 2));
         end
         checks++;
         if (tick !== ((k % 2) == 0)) begin
            errors++; $display("FAIL basic_tick cyc=%0d got=%b exp=%b", k, tick, (k % 2) == 0);
         end
         checks++;
         if (count_enable !== 1'b1) begin
            errors++; $display("FAIL basic_ce cyc=%0d got=%b exp=1", k, count_enable);
         end
      end
   endtask

   task automatic test_wrap_up();
      logic [7:0] exp;
      load = 1'b1; TDR = 8'hFE; cks = 2'b01; count_up_down = 1'b0;
      clk1();
      load = 1'b0;
      for (int k = 0; k < 9; k++) begin
         if (k > 0) clk1();
         exp = (k < 4) ? 8'hFE : (k < 8) ? 8'hFF : 8'h00;
         checks++;
         if (TCNT !== exp || count_enable !== 1'b1 || tick !== (k == 4 || k == 8)) begin
            errors++;
            $display("FAIL wrap_up k=%0d tcnt=%h exp=%h ce=%b tick=%b", k, TCNT, exp, count_enable, tick);
         end
      end
   endtask

   task automatic test_wrap_down_flip();
      logic [7:0] exp;
      load = 1'b1; TDR = 8'h01; cks = 2'b11; count_up_down = 1'b1;
      clk1();
      load = 1'b0;
      for (int k = 1; k <= 48; k++) begin
         if (k == 41) count_up_down = 1'b0;
         clk1();
         exp = (k < 16) ? 8'h01 : (k < 32) ? 8'h00 : (k < 48) ? 8'hFF : 8'h00;
         checks++;
         if (TCNT !== exp || tick !== (k == 16 || k == 32 || k == 48)) begin
            errors++; $display("FAIL wrap_down k=%0d tcnt=%h exp=%h tick=%b", k, TCNT, exp, tick);
         end
      end
   endtask

   task automatic test_load_collision();
      for (int k = 0; k < 15; k++) clk1();
      load = 1'b1; TDR = 8'h55;
      clk1();
      load = 1'b0;
      checks++;
      if (TCNT !== 8'h55 || tick !== 1'b0) begin
         errors++; $display("FAIL load_collide tcnt=%h exp=55 tick=%b exp=0", TCNT, tick);
      end
      for (int k = 1; k <= 16; k++) begin
         clk1();
         checks++;
         if (TCNT !== ((k < 16) ? 8'h55 : 8'h56) || tick !== (k == 16)) begin
            errors++; $display("FAIL load_next k=%0d tcnt=%h tick=%b", k, TCNT, tick);
         end
      end
   endtask

   task automatic test_cks_change();
      for (int k = 0; k < 9; k++) clk1();
      cks = 2'b00;
      for (int k = 1; k <= 3; k++) begin
         clk1();
         checks++;
         if (TCNT !== ((k < 3) ? 8'h56 : 8'h57) || tick !== (k == 3)) begin
            errors++; $display("FAIL cks_change k=%0d tcnt=%h tick=%b", k, TCNT, tick);
         end
      end
   endtask

   task automatic test_en_drop();
      clk1();
      timer_en = 1'b0;
      for (int k = 0; k < 3; k++) begin
         clk1();
         checks++;
         if (count_enable !== 1'b0 || TCNT !== 8'h57 || tick !== 1'b0) begin
            errors++; $display("FAIL en_drop k=%0d ce=%b tcnt=%h tick=%b exp 0/57/0", k, count_enable, TCNT, tick);
         end
      end
      timer_en = 1'b1;
      for (int k = 1; k <= 2; k++) begin
         clk1();
         checks++;
         if (count_enable !== 1'b1 || TCNT !== ((k < 2) ? 8'h57 : 8'h58) || tick !== (k == 2)) begin
            errors++; $display("FAIL en_resume k=%0d ce=%b tcnt=%h tick=%b", k, count_enable, TCNT, tick);
         end
      end
   endtask

   task automatic test_reset_midcount();
      clk1();
      preset_n = 1'b0;
      clk1();
      checks++;
      if (TCNT !== 8'h00 || count_enable !== 1'b0 || tick !== 1'b0) begin
         errors++; $display("FAIL reset_mid tcnt=%h ce=%b tick=%b exp all 0", TCNT, count_enable, tick);
      end
      preset_n = 1'b1;
   endtask

   task automatic test_random();
      logic [7:0] prev;
      for (int k = 0; k < 3000; k++) begin
         prev          = TCNT;
         preset_n      = ($urandom_range(0, 199) != 0);
         load          = ($urandom_range(0, 39) == 0);
         TDR           = 8'($urandom);
         timer_en      = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 29) == 0) cks = 2'($urandom);
         if ($urandom_range(0, 19) == 0) count_up_down = ~count_up_down;
         clk1();
         checks++;
         if (TCNT !== 8'(m_tcnt) || tick !== m_tick || count_enable !== m_ce) begin
            errors++;
            $display("FAIL random k=%0d tcnt=%h/%h tick=%b/%b ce=%b/%b (got/exp)",
                     k, TCNT, 8'(m_tcnt), tick, m_tick, count_enable, m_ce);
         end
         if (tick === 1'b1) begin
            checks++;
            if (TCNT !== prev + 8'd1 && TCNT !== prev - 8'd1) begin
               errors++; $display("FAIL single_step k=%0d prev=%h now=%h", k, prev, TCNT);
            end
         end
      end
   endtask

   initial begin
      preset_n = 1'b0; TDR = 8'h00; load = 1'b0; timer_en = 1'b0;
      count_up_down = 1'b0; cks = 2'b00;
      test_reset();
      test_basic();
      test_wrap_up();
      test_wrap_down_flip();
      test_load_collision();
      test_cks_change();
      test_en_drop();
      test_reset_midcount();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/tcnt_counter.md
# tcnt_counter

Generates the 8-bit timer count value `TCNT` and its enable qualifier for the single 8-bit timer. The overflow/underflow comparator consumes both outputs. The block contains:
- a prescaler that divides `pclk` by 2, 4, 8 or 16;
- a software load path from the data register;
- an up/down counter that wraps at 8'hFF / 8'h00.

It is the producer side of the `TCNT`/`count_enable`/`count_up_down` interface. Wrap-arounds must appear as single-step transitions so the comparator can detect them.

## Interface
- `DATA_WIDTH`, default 8 (`` `DATA_WIDTH `` from `reg_def.sv`): counter and register width.
- `pclk`  input  1  system clock; the only clock.
- `preset_n`  input  1  reset, synchronous, active-low.
- `TDR`  input  DATA_WIDTH  load value from the Timer Data Register.
- `load`  input  1  single-cycle pulse that copies `TDR` into `TCNT`.
- `timer_en`  input  1  level; 1 = counting allowed.
- `count_up_down`  input  1  0 = count up, 1 = count down.
- `cks`  input  2  prescaler select: 00 = /2, 01 = /4, 10 = /8, 11 = /16.
- `TCNT`  output  DATA_WIDTH  current count, registered.
- `count_enable`  output  1  registered; 1 while in state COUNT.
- `tick`  output  1  registered, one-cycle pulse; high in the cycle after `TCNT` stepped, i.e. coincident with the new value.

## Operation
- States:
  - IDLE: `timer_en` = 0. Hold `TCNT`; divider held at 0.
  - COUNT: prescaler runs and `TCNT` steps.
- Transitions:
  - IDLE -> COUNT on `timer_en` = 1.
  - COUNT -> IDLE on `timer_en` = 0.
  - No other transitions.
- Divider: 4-bit `div_cnt`, terminal value N-1, where N = 2 << `cks`.
  - In COUNT: if `div_cnt` == N-1, set `div_cnt` to 0 and step `TCNT`; otherwise increment `div_cnt`.
- Step: if `count_up_down` = 0, `TCNT` + 1; if 1, `TCNT` - 1. Arithmetic is modulo 2^DATA_WIDTH.
  - Up: 8'hFF -> 8'h00.
  - Down: 8'h00 -> 8'hFF.
  - No saturation and no skipped values.
- Load, any state: `TCNT` <= `TDR` and `div_cnt` <= 0. `tick` stays 0 in the following cycle.
  - Load has priority over a same-cycle step; the step is discarded.
- Any change of `cks` between consecutive cycles clears `div_cnt` to 0. This avoids a missed terminal count when N shrinks below the current `div_cnt`.
- A `count_up_down` change takes effect at the next step. The divider is not reset.
- `timer_en` falling: `div_cnt` clears. A step in the same cycle as `timer_en` = 0 does not occur.

## Timing
- Reset (`preset_n` = 0 at a rising edge):
  - `TCNT` = 0, `count_enable` = 0, `tick` = 0, `div_cnt` = 0, state IDLE.
  - All other inputs are ignored during reset.
  - Reset mid-count aborts the count immediately; no partial step.
- `count_enable` rises on the first edge that samples `timer_en` = 1. It falls on the first edge that samples `timer_en` = 0.
- First step: on the N-th consecutive rising edge that samples `timer_en` = 1. After that, one step every N cycles.
- Period: N cycles from step to step; `tick` is high 1 of every N cycles.
- Load latency: `TCNT` = `TDR` visible one cycle after the edge that samples `load`. The next step follows N edges later if enabled.
- `cks` change: the new period starts counting from the edge that samples the new `cks`.
- Wrap transitions occur only with `count_enable` = 1. `TCNT` holds for at least one cycle either side of a step, so `TCNT` is compared against its own previous-cycle value across at most one step.

## Test plan
- Reset, then `cks` = 00, `count_up_down` = 0, `timer_en` = 1 for 10 cycles:
  - `TCNT` = 0,0,1,1,2,2,3,3,4,4.
  - `tick` high in the cycles showing 1, 2, 3 and 4.
  - `count_enable` = 1 from cycle 1.
- Load `TDR` = 8'hFE with `cks` = 01, count up:
  - 8'hFE held 4 cycles, then 8'hFF, then 8'h00 exactly 4 cycles later.
  - No skipped values; `count_enable` = 1 across the wrap.
- Load 8'h01 with `cks` = 11, count down:
  - Steps 8'h01 -> 8'h00 -> 8'hFF at 16-cycle spacing.
  - Flip to count up mid-period: the next step is 8'hFF -> 8'h00 with no divider restart.
- Assert `load` (`TDR` = 8'h55) on the same edge where `div_cnt` == N-1:
  - `TCNT` = 8'h55, not the stepped value.
  - `tick` = 0; the next step is N cycles later.
- Change `cks` 11 -> 00 when `div_cnt` = 9:
  - `div_cnt` clears and a step occurs 2 edges later.
- Drop `timer_en` for 3 cycles mid-period:
  - `count_enable` = 0 and `TCNT` holds.
  - On re-enable, a full N cycles pass before the next step.
- Pulse `preset_n` = 0 mid-count:
  - All outputs are 0 on the next cycle.
